// File: rtl/msalu_pkg.sv
// msalu_pkg: opcode, function-select and sequencer state definitions shared by msalu_ctrl and msALU.
package msalu_pkg;
    typedef enum logic [3:0] {
        OP_LOAD = 4'd0,
        OP_MOV  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_INV  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7
    } op_t;
    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_SUB = 3'd1;
    localparam logic [2:0] FN_INV = 3'd2;
    localparam logic [2:0] FN_AND = 3'd3;
    localparam logic [2:0] FN_OR  = 3'd4;
    localparam logic [2:0] FN_XOR = 3'd5;
    typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;
    function automatic logic [2:0] fn_of(input logic [3:0] op);
        return op[2:0] - 3'd2;
    endfunction
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: register index to one-hot enable vector, all zero when disabled.
module onehot_dec #(
    parameter int RW = 3
) (
    input  logic [RW-1:0]    idx,
    input  logic             en,
    output logic [2**RW-1:0] oh
);
    localparam int NREG = 2**RW;
    assign oh = en ? ({{(NREG-1){1'b0}}, 1'b1} << idx) : '0;
endmodule

// File: rtl/msalu_ctrl.sv
// msalu_ctrl: decodes a latched instruction and sequences the msALU bus strobes, one instruction per EXEC rise.
module msalu_ctrl
    import msalu_pkg::*;
#(
    parameter int RW = 3
) (
    input  logic             CLKb,
    input  logic             RST,
    input  logic [3+2*RW:0]  INSTR,
    input  logic             EXEC,
    output logic [2**RW-1:0] Rout,
    output logic [2**RW-1:0] Rin,
    output logic             ExtOut,
    output logic             Ain,
    output logic             Gin,
    output logic             Gout,
    output logic [2:0]       FN,
    output logic             BUSY,
    output logic             DONE
);
    localparam int IW = 4 + 2*RW;

    state_t          state_q, state_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic            exec_q, exec_d;
    logic [3:0]      op;
    logic [RW-1:0]   rx, ry, rout_idx;
    logic            is_alu, t1, t2, t3, t4, rout_en, rin_en;

    assign op     = ir_q[IW-1 -: 4];
    assign rx     = ir_q[2*RW-1 -: RW];
    assign ry     = ir_q[RW-1:0];
    assign is_alu = (op >= OP_ADD) && (op <= OP_XOR);

    always_ff @(negedge CLKb or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ir_q    <= '0;
            exec_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            exec_q  <= exec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        exec_d  = EXEC;
        case (state_q)
            IDLE: if (EXEC && !exec_q) begin
                state_d = T1;
                ir_d    = INSTR;
            end
            T1:      state_d = is_alu ? T2 : IDLE;
            T2:      state_d = T3;
            T3:      state_d = T4;
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state and IR, so reset clears them at once.
    always_comb begin
        t1       = state_q == T1;
        t2       = state_q == T2;
        t3       = state_q == T3;
        t4       = state_q == T4;
        ExtOut   = t1 && op == OP_LOAD;
        rout_en  = (t1 && (op == OP_MOV || is_alu)) || t2;
        rout_idx = (t1 && is_alu) ? rx : ry;
        rin_en   = (t1 && (op == OP_LOAD || op == OP_MOV)) || t4;
        Ain      = t1 && is_alu;
        Gin      = t2;
        Gout     = t3;
        FN       = t2 ? fn_of(op) : FN_ADD;
        BUSY     = state_q != IDLE;
        DONE     = (t1 && !is_alu) || t4;
    end

    onehot_dec #(.RW(RW)) u_rout (.idx(rout_idx), .en(rout_en), .oh(Rout));
    onehot_dec #(.RW(RW)) u_rin  (.idx(rx),       .en(rin_en),  .oh(Rin));
endmodule
